// File: rtl/keycode_evt_pkg.sv
// Shared definitions for the multi-key keyboard event controller: register map,
// status bit positions, scan FSM states and the event record layout.
package keycode_evt_pkg;

  localparam logic [3:0] ADDR_COMMIT = 4'd8;
  localparam logic [3:0] ADDR_CTRL   = 4'd9;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_OVF    = 1;
  localparam int STAT_CERR   = 2;
  localparam int STAT_IRQ_EN = 3;
  localparam int STAT_CNT_LSB = 8;

  // Widest keycode the block can be built with; records are sized for it.
  localparam int MAX_CODE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REL  = 2'd1,
    PRS  = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic                  press;
    logic [MAX_CODE_W-1:0] code;
  } evt_rec_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO with occupancy count; a pop frees a slot for a push
// in the same cycle even when full.
module evt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keycode_event_ctrl.sv
// Avalon-MM keyboard peripheral: staged HID reports are committed, diffed against
// the previous report and turned into press/release events on a stream FIFO.
module keycode_event_ctrl
  import keycode_evt_pkg::*;
#(
  parameter int NUM_KEYS   = 6,
  parameter int CODE_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [3:0]                 avs_address,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  output logic [NUM_KEYS*CODE_W-1:0] keycodes_export,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [CODE_W-1:0]          evt_code,
  output logic                       evt_press,
  output logic                       irq
);

  localparam int IDX_W = 3;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int EVT_W = CODE_W + 1;

  logic [CODE_W-1:0] stage_q [NUM_KEYS];
  logic [CODE_W-1:0] stage_d [NUM_KEYS];
  logic [CODE_W-1:0] cur_q   [NUM_KEYS];
  logic [CODE_W-1:0] cur_d   [NUM_KEYS];
  logic [CODE_W-1:0] prev_q  [NUM_KEYS];
  logic [CODE_W-1:0] prev_d  [NUM_KEYS];

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              cerr_q, cerr_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              wr_commit;
  logic [CODE_W-1:0] cand;
  logic              in_other, dup_before, emit;
  logic [EVT_W-1:0]  fifo_wdata, fifo_rdata;
  logic              fifo_empty, fifo_drop;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       rd_word;
  logic              unused_wdata;

  // Only the keycode field and the control bits of a write are meaningful.
  assign unused_wdata = ^avs_writedata;

  assign wr_commit = avs_write && (avs_address == ADDR_COMMIT);

  // Scan: REL walks prev against cur, PRS walks cur against prev; a code is
  // reported once, at its first slot, and only if the other report lacks it.
  always_comb begin
    cand       = '0;
    in_other   = 1'b0;
    dup_before = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx_q == IDX_W'(i)) cand = (state_q == REL) ? prev_q[i] : cur_q[i];
    end
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (((state_q == REL) ? cur_q[j] : prev_q[j]) == cand) in_other = 1'b1;
      if ((IDX_W'(j) < idx_q) && (((state_q == REL) ? prev_q[j] : cur_q[j]) == cand))
        dup_before = 1'b1;
    end
    emit       = (state_q != IDLE) && (cand != '0) && !in_other && !dup_before;
    fifo_wdata = {(state_q == PRS), cand};
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (avs_address == 4'(i)) rd_word = 32'(stage_q[i]);
    end
    if (avs_address == ADDR_CTRL) begin
      rd_word[STAT_BUSY]            = (state_q != IDLE);
      rd_word[STAT_OVF]             = ovf_q;
      rd_word[STAT_CERR]            = cerr_q;
      rd_word[STAT_IRQ_EN]          = irq_en_q;
      rd_word[STAT_CNT_LSB +: 8]    = 8'(fifo_count);
    end
  end

  always_comb begin
    stage_d  = stage_q;
    cur_d    = cur_q;
    prev_d   = prev_q;
    state_d  = state_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    cerr_d   = cerr_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;

    if (avs_write) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (avs_address == 4'(i)) stage_d[i] = avs_writedata[CODE_W-1:0];
      end
      if (avs_address == ADDR_CTRL) begin
        if (avs_writedata[STAT_OVF])  ovf_d  = 1'b0;
        if (avs_writedata[STAT_CERR]) cerr_d = 1'b0;
        irq_en_d = avs_writedata[STAT_IRQ_EN];
      end
    end

    case (state_q)
      IDLE: begin
        if (wr_commit) begin
          prev_d  = cur_q;
          cur_d   = stage_q;
          state_d = REL;
          idx_d   = '0;
        end
      end
      REL: begin
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = PRS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      PRS: begin
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Hardware-set sticky bits win over a software clear in the same cycle.
    if (wr_commit && (state_q != IDLE)) cerr_d = 1'b1;
    if (fifo_drop) ovf_d = 1'b1;

    if (avs_read) rdata_d = rd_word;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        stage_q[i] <= '0;
        cur_q[i]   <= '0;
        prev_q[i]  <= '0;
      end
      state_q  <= IDLE;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      stage_q  <= stage_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      cerr_q   <= cerr_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (emit),
    .wdata (fifo_wdata),
    .pop   (evt_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  always_comb begin
    keycodes_export = '0;
    for (int i = 0; i < NUM_KEYS; i++) keycodes_export[i*CODE_W +: CODE_W] = cur_q[i];
  end

  assign avs_readdata = rdata_q;
  assign evt_valid    = ~fifo_empty;
  assign evt_code     = evt_valid ? fifo_rdata[CODE_W-1:0] : '0;
  assign evt_press    = evt_valid & fifo_rdata[CODE_W];
  assign irq          = irq_en_q & (evt_valid | ovf_q);

endmodule
